// File: rtl/argmax_classifier_if.sv
// Handshake and data bundle between the final neuron layer and the argmax classifier.
interface argmax_classifier_if #(
    parameter int unsigned INTG_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 16,
    parameter int unsigned NUM_INPUTS = 10
);
    localparam int unsigned DATA_WIDTH  = INTG_WIDTH + FRAC_WIDTH;
    localparam int unsigned INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic                          input_ready;
    logic signed [DATA_WIDTH-1:0]  inputs [NUM_INPUTS];
    logic        [INDEX_WIDTH-1:0] index;
    logic signed [DATA_WIDTH-1:0]  max_value;
    logic                          output_ready;
    logic                          busy;

    // Upstream / observer side
    modport master (
        output input_ready,
        output inputs,
        input  index,
        input  max_value,
        input  output_ready,
        input  busy
    );

    // Classifier side
    modport slave (
        input  input_ready,
        input  inputs,
        output index,
        output max_value,
        output output_ready,
        output busy
    );
endinterface

// File: rtl/argmax_classifier.sv
// Argmax classifier: snapshots all neuron scores, scans them one per cycle and
// reports the index and value of the largest signed score (lowest index on ties).
module argmax_classifier #(
    parameter int unsigned INTG_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 16,
    parameter int unsigned NUM_INPUTS = 10
) (
    input logic               clock,
    input logic               reset,
    argmax_classifier_if.slave bus
);
    localparam int unsigned DATA_WIDTH  = INTG_WIDTH + FRAC_WIDTH;
    localparam int unsigned INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    // With a single class there is nothing to scan, so the pointer stays at 0.
    localparam logic [INDEX_WIDTH-1:0] FirstPtr = (NUM_INPUTS > 1) ? INDEX_WIDTH'(1) : '0;
    localparam logic [INDEX_WIDTH-1:0] LastPtr  = INDEX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {StWaiting, StComparing, StDone} state_e;

    state_e                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  snapshot_q [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  snapshot_d [NUM_INPUTS];
    logic        [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic signed [DATA_WIDTH-1:0]  best_value_q, best_value_d;
    logic        [INDEX_WIDTH-1:0] best_index_q, best_index_d;
    logic        [INDEX_WIDTH-1:0] index_q, index_d;
    logic signed [DATA_WIDTH-1:0]  max_value_q, max_value_d;
    logic                          output_ready_q, output_ready_d;
    logic                          busy_q, busy_d;
    logic                          cand_greater;

    // Strict signed compare keeps the earlier index on ties.
    assign cand_greater = snapshot_q[ptr_q] > best_value_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        snapshot_d   = snapshot_q;
        ptr_d        = ptr_q;
        best_value_d = best_value_q;
        best_index_d = best_index_q;
        index_d      = index_q;
        max_value_d  = max_value_q;

        unique case (state_q)
            StWaiting: begin
                if (bus.input_ready) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        snapshot_d[i] = bus.inputs[i];
                    end
                    best_value_d = bus.inputs[0];
                    best_index_d = '0;
                    ptr_d        = FirstPtr;
                    if (NUM_INPUTS > 1) begin
                        state_d = StComparing;
                    end else begin
                        state_d     = StDone;
                        index_d     = '0;
                        max_value_d = bus.inputs[0];
                    end
                end
            end
            StComparing: begin
                if (cand_greater) begin
                    best_value_d = snapshot_q[ptr_q];
                    best_index_d = ptr_q;
                end
                if (ptr_q == LastPtr) begin
                    // Publish including the last element's comparison.
                    state_d     = StDone;
                    index_d     = cand_greater ? ptr_q : best_index_q;
                    max_value_d = cand_greater ? snapshot_q[ptr_q] : best_value_q;
                end else begin
                    ptr_d = ptr_q + INDEX_WIDTH'(1);
                end
            end
            StDone: begin
                if (!bus.input_ready) begin
                    state_d = StWaiting;
                end
            end
            default: state_d = StWaiting;
        endcase

        busy_d = (state_d == StComparing);
        // Result flag trails DONE entry by one edge and drops with input_ready.
        output_ready_d = (state_q == StDone) && bus.input_ready;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StWaiting;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                snapshot_q[i] <= '0;
            end
            ptr_q          <= '0;
            best_value_q   <= '0;
            best_index_q   <= '0;
            index_q        <= '0;
            max_value_q    <= '0;
            output_ready_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            snapshot_q     <= snapshot_d;
            ptr_q          <= ptr_d;
            best_value_q   <= best_value_d;
            best_index_q   <= best_index_d;
            index_q        <= index_d;
            max_value_q    <= max_value_d;
            output_ready_q <= output_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.index        = index_q;
    assign bus.max_value    = max_value_q;
    assign bus.output_ready = output_ready_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier (10-class and single-class instances).
module tb_argmax_classifier;
    typedef logic signed [31:0] frame_t [10];

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    argmax_classifier_if #(.INTG_WIDTH(16), .FRAC_WIDTH(16), .NUM_INPUTS(10)) bus ();
    argmax_classifier_if #(.INTG_WIDTH(16), .FRAC_WIDTH(16), .NUM_INPUTS(1))  bus1 ();

    argmax_classifier #(.INTG_WIDTH(16), .FRAC_WIDTH(16), .NUM_INPUTS(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    argmax_classifier #(.INTG_WIDTH(16), .FRAC_WIDTH(16), .NUM_INPUTS(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // Reference: maximum value first, then the first position holding it.
    task automatic ref_max(input frame_t v, output int idx, output logic signed [31:0] mx);
        mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            if (idx < 0 && v[i] == mx) idx = i;
        end
    endtask

    task automatic drive_frame(input frame_t v);
        @(negedge clock);
        for (int i = 0; i < 10; i++) bus.inputs[i] = v[i];
        bus.input_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        bus.input_ready = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // lat counts edges after the sampling edge; -1 on timeout.
    task automatic wait_result(input int first, output int lat, output int busy_cnt);
        lat = first;
        busy_cnt = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.busy) busy_cnt++;
            if (bus.output_ready) return;
        end
        lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.input_ready = 1'b0;
        bus1.input_ready = 1'b0;
        for (int i = 0; i < 10; i++) bus.inputs[i] = 32'sh1234_5678;
        bus1.inputs[0] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++; if (bus.index !== 4'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", bus.index); end
        n_checks++; if (bus.max_value !== 32'sd0) begin n_fail++; $display("FAIL reset_max got %h want 0", bus.max_value); end
        n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.output_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus1.output_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got %b want 0", bus1.output_ready); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        frame_t v;
        int lat, bc;
        for (int i = 0; i < 10; i++) v[i] = 32'(i) << 16;
        drive_frame(v);
        wait_result(-1, lat, bc);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL basic_latency got %0d want 10", lat); end
        n_checks++; if (bc != 9) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
        n_checks++; if (bus.index !== 4'd9) begin n_fail++; $display("FAIL basic_index got %0d want 9", bus.index); end
        n_checks++; if (bus.max_value !== 32'sh0009_0000) begin n_fail++; $display("FAIL basic_max got %h want 00090000", bus.max_value); end
        idle(2);
    endtask

    task automatic test_negative_tie();
        frame_t v;
        int lat, bc;
        for (int i = 0; i < 10; i++) v[i] = 32'shFFFF_0000;
        v[3] = 32'shFFFF_8000;
        v[7] = 32'shFFFF_8000;
        drive_frame(v);
        wait_result(-1, lat, bc);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL neg_latency got %0d want 10", lat); end
        n_checks++; if (bus.index !== 4'd3) begin n_fail++; $display("FAIL neg_index got %0d want 3", bus.index); end
        n_checks++; if (bus.max_value !== 32'shFFFF_8000) begin n_fail++; $display("FAIL neg_max got %h want ffff8000", bus.max_value); end
        idle(2);
    endtask

    task automatic test_snapshot();
        frame_t v;
        int lat, bc;
        for (int i = 0; i < 10; i++) v[i] = '0;
        v[5] = 32'sh0005_0000;
        drive_frame(v);
        @(posedge clock);
        @(negedge clock);
        bus.inputs[5] = '0;
        bus.inputs[2] = 32'sh7FFF_FFFF;
        wait_result(0, lat, bc);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL snap_latency got %0d want 10", lat); end
        n_checks++; if (bus.index !== 4'd5) begin n_fail++; $display("FAIL snap_index got %0d want 5", bus.index); end
        n_checks++; if (bus.max_value !== 32'sh0005_0000) begin n_fail++; $display("FAIL snap_max got %h want 00050000", bus.max_value); end
        idle(2);
    endtask

    task automatic test_hold_rearm();
        frame_t v;
        int lat, bc, eidx, bad;
        logic signed [31:0] emax;
        for (int i = 0; i < 10; i++) v[i] = $urandom;
        ref_max(v, eidx, emax);
        drive_frame(v);
        wait_result(-1, lat, bc);
        n_checks++; if (int'(bus.index) != eidx) begin n_fail++; $display("FAIL hold_index got %0d want %0d", bus.index, eidx); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 10; i++) bus.inputs[i] = $urandom;
            @(negedge clock);
            if (bus.output_ready !== 1'b1 || bus.busy !== 1'b0 || int'(bus.index) != eidx
                || bus.max_value !== emax) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        bus.input_ready = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL rearm_drop got %b want 0", bus.output_ready); end
        n_checks++; if (bus.max_value !== emax) begin n_fail++; $display("FAIL rearm_keep got %h want %h", bus.max_value, emax); end
        v[0] = 32'sh7000_0000;
        for (int i = 1; i < 10; i++) v[i] = {4'b0000, 28'($urandom)};
        for (int i = 0; i < 10; i++) bus.inputs[i] = v[i];
        bus.input_ready = 1'b1;
        wait_result(-1, lat, bc);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL rearm_latency got %0d want 10", lat); end
        n_checks++; if (bus.index !== 4'd0) begin n_fail++; $display("FAIL rearm_index got %0d want 0", bus.index); end
        n_checks++; if (bus.max_value !== 32'sh7000_0000) begin n_fail++; $display("FAIL rearm_max got %h want 70000000", bus.max_value); end
        idle(2);
    endtask

    task automatic test_reset_mid_scan();
        frame_t v;
        int lat, bc, eidx;
        logic signed [31:0] emax;
        for (int i = 0; i < 10; i++) v[i] = $urandom;
        drive_frame(v);
        @(posedge clock);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (bus.output_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b want 0", bus.output_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.index !== 4'd0) begin n_fail++; $display("FAIL midrst_index got %0d want 0", bus.index); end
        n_checks++; if (bus.max_value !== 32'sd0) begin n_fail++; $display("FAIL midrst_max got %h want 0", bus.max_value); end
        reset = 1'b1;
        bus.input_ready = 1'b0;
        idle(1);
        for (int i = 0; i < 10; i++) v[i] = $urandom;
        ref_max(v, eidx, emax);
        drive_frame(v);
        wait_result(-1, lat, bc);
        n_checks++; if (lat != 10) begin n_fail++; $display("FAIL midrst_latency got %0d want 10", lat); end
        n_checks++; if (int'(bus.index) != eidx) begin n_fail++; $display("FAIL midrst_index2 got %0d want %0d", bus.index, eidx); end
        n_checks++; if (bus.max_value !== emax) begin n_fail++; $display("FAIL midrst_max2 got %h want %h", bus.max_value, emax); end
        idle(2);
    endtask

    task automatic test_random();
        frame_t v;
        int lat, bc, eidx;
        logic signed [31:0] emax;
        for (int f = 0; f < 25; f++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 10; i++) begin
                if (mode == 0) v[i] = $urandom;
                else if (mode == 1) v[i] = 32'($signed($urandom_range(0, 3))) - 32'sd2;
                else v[i] = {1'b1, 31'($urandom)};
            end
            ref_max(v, eidx, emax);
            drive_frame(v);
            wait_result(-1, lat, bc);
            n_checks++; if (lat != 10) begin n_fail++; $display("FAIL rand%0d_latency got %0d want 10", f, lat); end
            n_checks++; if (int'(bus.index) != eidx) begin n_fail++; $display("FAIL rand%0d_index got %0d want %0d", f, bus.index, eidx); end
            n_checks++; if (bus.max_value !== emax) begin n_fail++; $display("FAIL rand%0d_max got %h want %h", f, bus.max_value, emax); end
            idle($urandom_range(1, 3));
        end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clock);
        bus1.inputs[0] = 32'sh8000_0000;
        bus1.input_ready = 1'b1;
        lat = -1;
        for (int c = 0; c < 16 && lat < 0; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus1.output_ready) lat = c;
        end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", lat); end
        n_checks++; if (bus1.index !== 1'b0) begin n_fail++; $display("FAIL single_index got %0d want 0", bus1.index); end
        n_checks++; if (bus1.max_value !== 32'sh8000_0000) begin n_fail++; $display("FAIL single_max got %h want 80000000", bus1.max_value); end
        bus1.input_ready = 1'b0;
        @(negedge clock);
        n_checks++; if (bus1.output_ready !== 1'b0) begin n_fail++; $display("FAIL single_drop got %b want 0", bus1.output_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_tie();
        test_snapshot();
        test_hold_rearm();
        test_reset_mid_scan();
        test_random();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
